// File: rtl/mc_controller_pkg.sv
// Shared encodings for the multi-cycle RV32I controller: FSM states, opcodes and
// datapath select codes.
package mc_controller_pkg;

  localparam logic [3:0] StFetch    = 4'd0;
  localparam logic [3:0] StDecode   = 4'd1;
  localparam logic [3:0] StMemAdr   = 4'd2;
  localparam logic [3:0] StMemRead  = 4'd3;
  localparam logic [3:0] StMemWb    = 4'd4;
  localparam logic [3:0] StMemWrite = 4'd5;
  localparam logic [3:0] StExecR    = 4'd6;
  localparam logic [3:0] StExecI    = 4'd7;
  localparam logic [3:0] StAluWb    = 4'd8;
  localparam logic [3:0] StBeq      = 4'd9;
  localparam logic [3:0] StJal      = 4'd10;
  localparam logic [3:0] StHalt     = 4'd11;

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpRType  = 7'b0110011;
  localparam logic [6:0] OpIType  = 7'b0010011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;

  typedef enum logic [1:0] {
    AluOpAdd   = 2'b00,
    AluOpSub   = 2'b01,
    AluOpFunct = 2'b10
  } alu_op_e;

  localparam logic [2:0] AluAdd = 3'b000;
  localparam logic [2:0] AluSub = 3'b001;
  localparam logic [2:0] AluAnd = 3'b010;
  localparam logic [2:0] AluOr  = 3'b011;
  localparam logic [2:0] AluSlt = 3'b101;

  localparam logic [1:0] ImmI = 2'b00;
  localparam logic [1:0] ImmS = 2'b01;
  localparam logic [1:0] ImmB = 2'b10;
  localparam logic [1:0] ImmJ = 2'b11;

  localparam logic [1:0] ResAluOut = 2'b00;
  localparam logic [1:0] ResData   = 2'b01;
  localparam logic [1:0] ResAluRes = 2'b10;

  localparam logic [1:0] SrcAPc    = 2'b00;
  localparam logic [1:0] SrcAOldPc = 2'b01;
  localparam logic [1:0] SrcARd1   = 2'b10;

  localparam logic [1:0] SrcBRd2  = 2'b00;
  localparam logic [1:0] SrcBImm  = 2'b01;
  localparam logic [1:0] SrcBFour = 2'b10;

  function automatic logic [1:0] imm_src_of(input logic [6:0] op);
    logic [1:0] imm;
    imm = ImmI;
    if (op == OpStore) imm = ImmS;
    else if (op == OpBranch) imm = ImmB;
    else if (op == OpJal) imm = ImmJ;
    return imm;
  endfunction

endpackage

// File: rtl/mc_controller_alu_dec.sv
// ALU control decoder: maps ALUOp plus instruction function bits to the ALU operation.
module alu_dec
  import mc_controller_pkg::*;
(
  input  logic [1:0] aluop_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  input  logic       op5_i,
  output logic [2:0] alucon_o
);

  always_comb begin
    alucon_o = AluAdd;
    case (aluop_i)
      AluOpSub: alucon_o = AluSub;
      AluOpFunct: begin
        case (funct3_i)
          3'b000:  alucon_o = (op5_i && funct7b5_i) ? AluSub : AluAdd;
          3'b010:  alucon_o = AluSlt;
          3'b110:  alucon_o = AluOr;
          3'b111:  alucon_o = AluAnd;
          default: alucon_o = AluAdd;
        endcase
      end
      default: alucon_o = AluAdd;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multi-cycle RV32I control FSM: sequences each instruction through the shared ALU and
// unified memory, counts retired instructions and optionally halts on illegal opcodes.
module mc_controller
  import mc_controller_pkg::*;
#(
  parameter int unsigned CNT_W        = 32,
  parameter bit          ILLEGAL_HALT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       op,
  input  logic [2:0]       funct3,
  input  logic             funct7b5,
  input  logic             zf,
  output logic             PCWr,
  output logic             AdrSrc,
  output logic             MemWr,
  output logic             IRWr,
  output logic [1:0]       ResSrc,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [2:0]       ALUCon,
  output logic [1:0]       ImmSrc,
  output logic             RegWr,
  output logic             halted,
  output logic [CNT_W-1:0] instret
);

  logic [3:0]       state_q, state_d;
  logic [CNT_W-1:0] instret_q;
  alu_op_e          alu_op;
  logic             pc_upd, branch, ir_wr, mem_wr, reg_wr, retire;

  always_comb begin
    state_d = state_q;
    alu_op  = AluOpAdd;
    pc_upd  = 1'b0;
    branch  = 1'b0;
    ir_wr   = 1'b0;
    mem_wr  = 1'b0;
    reg_wr  = 1'b0;
    retire  = 1'b0;
    AdrSrc  = 1'b0;
    ResSrc  = ResAluOut;
    ALUSrcA = SrcAPc;
    ALUSrcB = SrcBRd2;
    case (state_q)
      StFetch: begin
        ir_wr   = 1'b1;
        pc_upd  = 1'b1;
        ALUSrcB = SrcBFour;
        ResSrc  = ResAluRes;
        state_d = StDecode;
      end
      StDecode: begin
        ALUSrcA = SrcAOldPc;
        ALUSrcB = SrcBImm;
        case (op)
          OpLoad, OpStore: state_d = StMemAdr;
          OpRType:         state_d = StExecR;
          OpIType:         state_d = StExecI;
          OpBranch:        state_d = StBeq;
          OpJal:           state_d = StJal;
          default:         state_d = ILLEGAL_HALT ? StHalt : StFetch;
        endcase
      end
      StMemAdr: begin
        ALUSrcA = SrcARd1;
        ALUSrcB = SrcBImm;
        state_d = op[5] ? StMemWrite : StMemRead;
      end
      StMemRead: begin
        AdrSrc  = 1'b1;
        state_d = StMemWb;
      end
      StMemWb: begin
        ResSrc  = ResData;
        reg_wr  = 1'b1;
        retire  = 1'b1;
        state_d = StFetch;
      end
      StMemWrite: begin
        AdrSrc  = 1'b1;
        mem_wr  = 1'b1;
        retire  = 1'b1;
        state_d = StFetch;
      end
      StExecR: begin
        ALUSrcA = SrcARd1;
        alu_op  = AluOpFunct;
        state_d = StAluWb;
      end
      StExecI: begin
        ALUSrcA = SrcARd1;
        ALUSrcB = SrcBImm;
        alu_op  = AluOpFunct;
        state_d = StAluWb;
      end
      StAluWb: begin
        reg_wr  = 1'b1;
        retire  = 1'b1;
        state_d = StFetch;
      end
      StBeq: begin
        ALUSrcA = SrcARd1;
        alu_op  = AluOpSub;
        branch  = 1'b1;
        retire  = 1'b1;
        state_d = StFetch;
      end
      StJal: begin
        ALUSrcA = SrcAOldPc;
        ALUSrcB = SrcBFour;
        pc_upd  = 1'b1;
        state_d = StAluWb;
      end
      StHalt:  state_d = StHalt;
      default: state_d = StFetch;
    endcase
  end

  alu_dec u_alu_dec (
    .aluop_i   (alu_op),
    .funct3_i  (funct3),
    .funct7b5_i(funct7b5),
    .op5_i     (op[5]),
    .alucon_o  (ALUCon)
  );

  // Write enables are gated by rst so a reset mid-instruction cannot corrupt state.
  assign PCWr    = ~rst & (pc_upd | (branch & zf));
  assign IRWr    = ~rst & ir_wr;
  assign MemWr   = ~rst & mem_wr;
  assign RegWr   = ~rst & reg_wr;
  assign ImmSrc  = imm_src_of(op);
  assign halted  = (state_q == StHalt);
  assign instret = instret_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StFetch;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      if (retire) instret_q <= instret_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mc_controller.sv
// Randomized self-checking bench for mc_controller: three instances (halting, skipping,
// 4-bit counter) compared every cycle against a per-instruction behavioural model.
module tb_mc_controller;

  typedef struct packed {
    logic       pcwr;
    logic       adrsrc;
    logic       memwr;
    logic       irwr;
    logic [1:0] ressrc;
    logic [1:0] srca;
    logic [1:0] srcb;
    logic [2:0] alucon;
    logic       regwr;
  } outs_t;

  logic       clk, rst, funct7b5, zf;
  logic [6:0] op;
  logic [2:0] funct3;

  logic [2:0] pcwr_v, adrsrc_v, memwr_v, irwr_v, regwr_v, halted_v;
  logic [1:0] ressrc_v [3];
  logic [1:0] srca_v   [3];
  logic [1:0] srcb_v   [3];
  logic [2:0] alucon_v [3];
  logic [1:0] immsrc_v [3];
  logic [31:0] instret0, instret1;
  logic [3:0]  instret2;

  mc_controller #(.CNT_W(32), .ILLEGAL_HALT(1'b1)) dut0 (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5), .zf(zf),
    .PCWr(pcwr_v[0]), .AdrSrc(adrsrc_v[0]), .MemWr(memwr_v[0]), .IRWr(irwr_v[0]),
    .ResSrc(ressrc_v[0]), .ALUSrcA(srca_v[0]), .ALUSrcB(srcb_v[0]), .ALUCon(alucon_v[0]),
    .ImmSrc(immsrc_v[0]), .RegWr(regwr_v[0]), .halted(halted_v[0]), .instret(instret0)
  );
  mc_controller #(.CNT_W(32), .ILLEGAL_HALT(1'b0)) dut1 (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5), .zf(zf),
    .PCWr(pcwr_v[1]), .AdrSrc(adrsrc_v[1]), .MemWr(memwr_v[1]), .IRWr(irwr_v[1]),
    .ResSrc(ressrc_v[1]), .ALUSrcA(srca_v[1]), .ALUSrcB(srcb_v[1]), .ALUCon(alucon_v[1]),
    .ImmSrc(immsrc_v[1]), .RegWr(regwr_v[1]), .halted(halted_v[1]), .instret(instret1)
  );
  mc_controller #(.CNT_W(4), .ILLEGAL_HALT(1'b1)) dut2 (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5), .zf(zf),
    .PCWr(pcwr_v[2]), .AdrSrc(adrsrc_v[2]), .MemWr(memwr_v[2]), .IRWr(irwr_v[2]),
    .ResSrc(ressrc_v[2]), .ALUSrcA(srca_v[2]), .ALUSrcB(srcb_v[2]), .ALUCon(alucon_v[2]),
    .ImmSrc(immsrc_v[2]), .RegWr(regwr_v[2]), .halted(halted_v[2]), .instret(instret2)
  );

  outs_t       got [3];
  logic [31:0] got_cnt [3];
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      got[i] = {pcwr_v[i], adrsrc_v[i], memwr_v[i], irwr_v[i], ressrc_v[i], srca_v[i],
                srcb_v[i], alucon_v[i], regwr_v[i]};
    end
    got_cnt[0] = instret0;
    got_cnt[1] = instret1;
    got_cnt[2] = {28'd0, instret2};
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  bit          chk_en = 1'b0;
  outs_t       exp_o [3];
  logic        exp_halt [3];
  int unsigned exp_cnt [3];
  logic [1:0]  exp_imm;
  outs_t       trace [$];
  logic        trace_halt [$];

  // ---------------- behavioural model ----------------
  function automatic bit is_legal(input logic [6:0] o);
    return o == 7'b0000011 || o == 7'b0100011 || o == 7'b0110011 || o == 7'b0010011 ||
           o == 7'b1100011 || o == 7'b1101111;
  endfunction

  function automatic int len_ref(input logic [6:0] o);
    case (o)
      7'b0000011:                         return 5;
      7'b0100011, 7'b0110011, 7'b0010011: return 4;
      7'b1101111:                         return 4;
      7'b1100011:                         return 3;
      default:                            return 0;
    endcase
  endfunction

  function automatic logic [1:0] imm_ref(input logic [6:0] o);
    if (o == 7'b0100011) return 2'b01;
    if (o == 7'b1100011) return 2'b10;
    if (o == 7'b1101111) return 2'b11;
    return 2'b00;
  endfunction

  function automatic logic [2:0] alu_ref(input logic [6:0] o, input logic [2:0] f3,
                                         input logic f7);
    case (f3)
      3'b000:  return (o[5] && f7) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  // Expected outputs in cycle k of an instruction (k=0 is its fetch).
  function automatic outs_t step_ref(input logic [6:0] o, input logic [2:0] f3,
                                     input logic f7, input logic z, input int k,
                                     input bit ih);
    outs_t s, fe, de;
    s  = '0;
    fe = '0; fe.pcwr = 1; fe.irwr = 1; fe.ressrc = 2'b10; fe.srcb = 2'b10;
    de = '0; de.srca = 2'b01; de.srcb = 2'b01;
    if (k == 0) return fe;
    if (k == 1) return de;
    case (o)
      7'b0000011, 7'b0100011: begin
        if (k == 2) begin s.srca = 2'b10; s.srcb = 2'b01; end
        else if (o[5]) begin s.adrsrc = 1; s.memwr = 1; end
        else if (k == 3) s.adrsrc = 1;
        else begin s.ressrc = 2'b01; s.regwr = 1; end
      end
      7'b0110011, 7'b0010011: begin
        if (k == 2) begin
          s.srca = 2'b10;
          s.srcb = (o == 7'b0010011) ? 2'b01 : 2'b00;
          s.alucon = alu_ref(o, f3, f7);
        end else s.regwr = 1;
      end
      7'b1100011: begin s.srca = 2'b10; s.alucon = 3'b001; s.pcwr = z; end
      7'b1101111: begin
        if (k == 2) begin s.srca = 2'b01; s.srcb = 2'b10; s.pcwr = 1; end
        else s.regwr = 1;
      end
      default: if (!ih) s = (k % 2 == 0) ? fe : de;
    endcase
    return s;
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 3; i++) begin
        int unsigned e;
        e = (i == 2) ? (exp_cnt[i] & 32'hF) : exp_cnt[i];
        checks++;
        if (got[i] !== exp_o[i]) begin
          failures++;
          $display("FAIL outs[%0d] t=%0t got=%h required=%h", i, $time, got[i], exp_o[i]);
        end
        checks++;
        if (halted_v[i] !== exp_halt[i]) begin
          failures++;
          $display("FAIL halted[%0d] t=%0t got=%b required=%b", i, $time, halted_v[i],
                   exp_halt[i]);
        end
        checks++;
        if (immsrc_v[i] !== exp_imm) begin
          failures++;
          $display("FAIL immsrc[%0d] t=%0t got=%b required=%b", i, $time, immsrc_v[i],
                   exp_imm);
        end
        checks++;
        if (got_cnt[i] !== e) begin
          failures++;
          $display("FAIL instret[%0d] t=%0t got=%0d required=%0d", i, $time, got_cnt[i], e);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic lit(input string name, input logic [31:0] g, input logic [31:0] e);
    checks++;
    if (g !== e) begin
      failures++;
      $display("FAIL %s got=%0h required=%0h", name, g, e);
    end
  endtask

  task automatic one_cycle(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                           input int zfix, input int k, input logic r);
    logic z;
    z = (zfix < 0) ? logic'($urandom_range(0, 1)) : logic'(zfix);
    op = o; funct3 = f3; funct7b5 = f7; zf = z; rst = r;
    for (int i = 0; i < 3; i++) begin
      outs_t s;
      s = step_ref(o, f3, f7, z, k, i != 1);
      if (r) begin s.pcwr = 0; s.irwr = 0; s.memwr = 0; s.regwr = 0; end
      exp_o[i]    = s;
      exp_halt[i] = (i != 1) && !is_legal(o) && k >= 2;
    end
    exp_imm = imm_ref(o);
    @(negedge clk);
    #1;
    trace.push_back(got[0]);
    trace_halt.push_back(halted_v[0]);
    @(posedge clk);
    #1;
    if (r) for (int i = 0; i < 3; i++) exp_cnt[i] = 0;
  endtask

  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                           input int zfix, input int abort_k);
    trace.delete();
    trace_halt.delete();
    for (int k = 0; k < len_ref(o); k++) begin
      one_cycle(o, f3, f7, zfix, k, k == abort_k);
      if (k == abort_k) return;
    end
    for (int i = 0; i < 3; i++) exp_cnt[i]++;
  endtask

  // Illegal opcode: 12 cycles free-running, then one reset cycle.
  task automatic run_illegal(input logic [6:0] o);
    trace.delete();
    trace_halt.delete();
    for (int k = 0; k < 13; k++) one_cycle(o, 3'b000, 1'b0, -1, k, k == 12);
  endtask

  task automatic rand_legal(output logic [6:0] o);
    logic [6:0] tbl [6];
    tbl[0] = 7'b0000011; tbl[1] = 7'b0100011; tbl[2] = 7'b0110011;
    tbl[3] = 7'b0010011; tbl[4] = 7'b1100011; tbl[5] = 7'b1101111;
    o = tbl[$urandom_range(0, 5)];
  endtask

  initial begin
    logic [6:0] o;
    rst = 1'b1; op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b0; zf = 1'b0;
    for (int i = 0; i < 3; i++) exp_cnt[i] = 0;
    @(posedge clk);
    #1;
    chk_en = 1'b1;
    one_cycle(7'b0110011, 3'b000, 1'b0, -1, 0, 1'b1);

    run_instr(7'b0110011, 3'b000, 1'b1, -1, -1);
    lit("r_sub_alucon", 32'(trace[2].alucon), 32'h1);
    lit("r_aluwb_regwr", 32'(trace[3].regwr), 32'h1);
    lit("instret_after_r", instret0, 32'd1);

    run_instr(7'b0000011, 3'b010, 1'b0, -1, -1);
    lit("lw_memread_adrsrc", 32'(trace[3].adrsrc), 32'h1);
    lit("lw_memwb_ressrc", 32'(trace[4].ressrc), 32'h1);
    lit("lw_memwb_regwr", 32'(trace[4].regwr), 32'h1);

    run_instr(7'b1100011, 3'b000, 1'b0, 1, -1);
    lit("beq_taken_pcwr", 32'(trace[2].pcwr), 32'h1);
    lit("beq_alucon", 32'(trace[2].alucon), 32'h1);
    run_instr(7'b1100011, 3'b000, 1'b0, 0, -1);
    lit("beq_nottaken_pcwr", 32'(trace[2].pcwr), 32'h0);
    lit("instret_after_beq", instret0, 32'd4);

    run_instr(7'b1101111, 3'b000, 1'b0, -1, -1);
    lit("jal_pcwr", 32'(trace[2].pcwr), 32'h1);
    lit("jal_srca", 32'(trace[2].srca), 32'h1);
    lit("jal_srcb", 32'(trace[2].srcb), 32'h2);
    lit("jal_aluwb_regwr", 32'(trace[3].regwr), 32'h1);

    run_illegal(7'b1111111);
    lit("halt_flag", 32'(trace_halt[11]), 32'h1);
    lit("halt_outs_zero", 32'(trace[11]), 32'h0);

    run_instr(7'b0100011, 3'b010, 1'b0, -1, 3);
    lit("sw_rst_memwr", 32'(trace[3].memwr), 32'h0);
    lit("instret_after_rst", instret0, 32'd0);

    for (int n = 0; n < 16; n++) begin
      rand_legal(o);
      run_instr(o, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), -1, -1);
    end
    lit("instret4_wrap", 32'(instret2), 32'd0);
    lit("instret32_16", instret0, 32'd16);

    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 11) == 0) begin
        do o = 7'($urandom_range(0, 127)); while (is_legal(o));
        run_illegal(o);
      end else begin
        rand_legal(o);
        run_instr(o, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), -1, -1);
      end
    end

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
